// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to transmitter and
// receiver) and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    idle  = 2'd0,
    start = 2'd1,
    data  = 2'd2,
    stop  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous input pins; flops reset to a
// configurable value so an idle-high line never looks like activity.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= RESET_VALUE;
      sync_reg <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, detects the start edge, samples each
// bit at mid-period and strobes done (good byte) or frame_error (bad stop).
module uart_rx
  import uart_pkg::*;
#(
  parameter int clock_bit = 5207
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] readdata,
  output logic       done,
  output logic       active,
  output logic       frame_error
);

  localparam int          IDX_W    = $clog2(DATA_BITS);
  localparam logic [15:0] BIT_LAST = 16'(clock_bit);
  localparam logic [15:0] HALF_BIT = 16'(clock_bit / 2);

  logic s2;
  logic s3_reg;
  logic fall;

  state_t                 state_reg, state_next;
  logic [15:0]            counter_reg, counter_next;
  logic [IDX_W-1:0]       index_reg, index_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   readdata_reg, readdata_next;
  logic                   done_reg, done_next;
  logic                   active_reg, active_next;
  logic                   frame_error_reg, frame_error_next;

  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (s2)
  );

  // Only a genuine high-to-low transition starts a frame, so a line stuck
  // low (break) cannot retrigger once the failed frame has ended.
  assign fall = s3_reg & ~s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s3_reg          <= 1'b1;
      state_reg       <= idle;
      counter_reg     <= '0;
      index_reg       <= '0;
      shift_reg       <= '0;
      readdata_reg    <= '0;
      done_reg        <= 1'b0;
      active_reg      <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      s3_reg          <= s2;
      state_reg       <= state_next;
      counter_reg     <= counter_next;
      index_reg       <= index_next;
      shift_reg       <= shift_next;
      readdata_reg    <= readdata_next;
      done_reg        <= done_next;
      active_reg      <= active_next;
      frame_error_reg <= frame_error_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    counter_next     = counter_reg;
    index_next       = index_reg;
    shift_next       = shift_reg;
    readdata_next    = readdata_reg;
    done_next        = 1'b0;
    active_next      = active_reg;
    frame_error_next = 1'b0;

    case (state_reg)
      idle: begin
        active_next  = 1'b0;
        counter_next = '0;
        if (fall) begin
          state_next  = start;
          active_next = 1'b1;
        end
      end

      // Re-check the start bit at its midpoint to reject short glitches.
      start: begin
        if (counter_reg == HALF_BIT) begin
          counter_next = '0;
          if (!s2) begin
            state_next = data;
            index_next = '0;
          end else begin
            state_next  = idle;
            active_next = 1'b0;
          end
        end else begin
          counter_next = counter_reg + 16'd1;
        end
      end

      data: begin
        if (counter_reg == BIT_LAST) begin
          counter_next          = '0;
          shift_next[index_reg] = s2;
          if (index_reg == IDX_W'(DATA_BITS - 1)) begin
            state_next = stop;
          end else begin
            index_next = index_reg + 1'b1;
          end
        end else begin
          counter_next = counter_reg + 16'd1;
        end
      end

      // Leaving at mid-stop gives half a bit of slack for the next start edge.
      stop: begin
        if (counter_reg == BIT_LAST) begin
          counter_next = '0;
          state_next   = idle;
          active_next  = 1'b0;
          if (s2) begin
            readdata_next = shift_reg;
            done_next     = 1'b1;
          end else begin
            frame_error_next = 1'b1;
          end
        end else begin
          counter_next = counter_reg + 16'd1;
        end
      end

      default: begin
        state_next   = idle;
        active_next  = 1'b0;
        counter_next = '0;
      end
    endcase
  end

  assign readdata    = readdata_reg;
  assign done        = done_reg;
  assign active      = active_reg;
  assign frame_error = frame_error_reg;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
RS232 receiver; the downstream partner of the bus UART transmitter, 8N1, LSB first, idle-high line. Synchronises the external rx pin and detects the start-bit falling edge. Samples each bit at mid-period and presents the received byte with a one-cycle done strobe to the bus-side logic. Bit timing uses the same clock_bit convention as the transmitter, so the pair interoperates when built with equal parameters.

Parameters:
clock_bit, 5207, bit period minus one in clock cycles; one bit = clock_bit+1 cycles (5207 → 9600 baud at 50 MHz); legal range 2..65534.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
rx  input  1  external serial line, asynchronous to clock, idle high
readdata  output  8  last correctly framed byte; held until next good frame
done  output  1  one-cycle pulse: readdata updated this cycle
active  output  1  high while a frame is being received (start..stop)
frame_error  output  1  one-cycle pulse: stop bit sampled low, byte discarded

Behaviour:
- Reset values: readdata=0, done=0, active=0, frame_error=0, all sync flops=1, state=idle, counter=0, index=0.
- Synchroniser:
  - Two flops rx→s1→s2, plus a third flop s3 holding the previous s2.
  - Falling edge = (s3==1 && s2==0).
  - Pin-to-s2 latency is 2 cycles.
- Counter: 16-bit, reset to 0 on every state entry, +1 per cycle in start/data/stop. Half period = clock_bit/2 (integer divide).
- States and transitions:
  - idle: active=0. On falling edge → start, counter=0, active=1. A line held low never re-triggers; a new high→low transition is required (break handling).
  - start: when counter==clock_bit/2, sample s2.
    - s2==0 → data, counter=0, index=0.
    - s2==1 → glitch: idle, active=0, no strobe.
  - data: when counter==clock_bit, shift register bit[index]=s2, counter=0.
    - index<7 → index+1, stay in data.
    - index==7 → stop.
  - stop: when counter==clock_bit, sample s2.
    - s2==1 → readdata=shift register, done=1 for exactly one cycle.
    - s2==0 → frame_error=1 for one cycle; readdata unchanged.
    - Either way → idle, active=0 in that same cycle.
  - default/illegal encoding → idle.
- Sampling points: middle of each bit. Stop sampled at mid-stop, so the receiver is back in idle half a bit early and catches a back-to-back start edge from a transmitter sending minimal stop.
- done and frame_error are mutually exclusive and never asserted in consecutive cycles.
- Latency: done rises 9.5 bit periods + 3..4 cycles after the rx pin falls (sync + edge register).
- Reset mid-frame: immediate return to reset values; the partial byte is lost; no strobe.
- Counter width: clock_bit above 65534 is illegal (not checked in RTL).

Decomposition:
- Shared package uart_pkg: 2-bit state encodings idle=0, start=1, data=2, stop=3 (same values as the transmitter), and constant DATA_BITS=8.
- One natural sub-module: sync_2ff (parameterised width, reset value 1), reused by any block taking an asynchronous pin.
- FSM, counter and shift register stay in uart_rx.

Test Plan:
- Loopback with uart_tx, both clock_bit=15, send 0xA5 → exactly one done pulse, readdata=0xA5, frame_error never high, active low again before tx done.
- Glitch: rx low 4 cycles then high (clock_bit=15) → active pulses high about 8 cycles, no done, no frame_error, readdata unchanged.
- Framing error: bit-bang 0x3C with stop bit 0 after a good 0xA5 → one frame_error pulse, no done, readdata stays 0xA5.
- Back-to-back: uart_tx sends 0x00 then 0xFF with enable held → two done pulses, readdata 0x00 then 0xFF, each within 9.5 bit periods ±4 cycles of its start edge.
- Reset mid-frame: assert reset after 3 data bits of 0x81 → readdata=0, active=0 immediately; next frame 0x5A → readdata=0x5A, single done.
- Break: rx low 30 bit periods, then high 2 bit periods, then frame 0x11 → exactly one frame_error during the break, then done with readdata=0x11.
